char_physics_core: RTL and testbench
====================================

// Module: char_physics_core
// PURPOSE
//  Parametrised character motion engine: walk, charged jump, gravity and arena-wall response.
//  Sits between button inputs and the VGA sprite renderer, like the first-generation character block.
//  Runs on sys_clk and advances physics only on a phy_tick strobe (replaces the separate character clock).
//  Adds swept boundary clamping, ceiling and wall handling, and multi-level charge over that block.
// PARAMETERS
//  PHY_WIDTH     10   signed pos/vel width is PHY_WIDTH+1
//  MAP_X_OFFSET  270  arena left edge (px)
//  MAP_Y_OFFSET  50   arena bottom edge (px; y increases upward)
//  MAP_WIDTH_X   200  arena width incl. walls
//  MAP_WIDTH_Y   300  arena height incl. walls
//  WALL_WIDTH    10   wall thickness
//  CHAR_W        32   sprite width
//  CHAR_H        32   sprite height
//  GRAVITY       1    vel_y decrement per airborne tick
//  MAX_VEL       40   |vel| saturation limit
//  WALK_STEP     2    px moved per walk request
//  JUMP_VX       4    vx per charge level
//  JUMP_VY       8    vy per charge level
//  CHARGE_LEVELS 4    number of charge levels
//  CHARGE_TICKS  4    ticks per charge level
// PORTS
//  sys_clk       in   1            system clock
//  sys_rst_n     in   1            async active-low reset
//  phy_tick      in   1            one-cycle physics step strobe
//  left_btn      in   1            raw button, async
//  right_btn     in   1            raw button, async
//  jump_btn      in   1            raw button, async
//  pos_x/pos_y   out  PHY_WIDTH+1  sprite bottom-left corner (signed)
//  vel_x/vel_y   out  PHY_WIDTH+1  current velocity (signed)
//  face          out  1            1 = facing +x (right), 0 = -x
//  state         out  2            0 IDLE, 1 CHARGE, 2 AIRBORNE, 3 LAND
//  charge_level  out  3            level of last/current charge (0 = none)
//  on_ground     out  1            1 in IDLE, CHARGE and LAND
//  wall_hit      out  1            1-sys_clk pulse on side-wall contact
//  land          out  1            1-sys_clk pulse on floor contact
// BEHAVIOUR
//  Single clock: sys_clk. Reset: sys_rst_n, asynchronous, active-low.
//  Reset: pos = (INIT_X, Y_MIN); vel = 0; face = 1; state = IDLE; charge_level = 0; pulses = 0; on_ground = 1.
//  Bounds: X_MIN = MAP_X_OFFSET+WALL_WIDTH; X_MAX = MAP_X_OFFSET+MAP_WIDTH_X-WALL_WIDTH-CHAR_W.
//  Y_MIN = MAP_Y_OFFSET+WALL_WIDTH; Y_MAX = MAP_Y_OFFSET+MAP_WIDTH_Y-WALL_WIDTH-CHAR_H.
//  INIT_X = X_MIN+(X_MAX-X_MIN)/2. Defaults give 280/428/60/308, INIT_X = 354.
//  Input path: 2-FF sync on each button, then rising-edge detect.
//  Left/right/jump edges set sticky request flags. All flags clear on every phy_tick, so no edge is lost between ticks.
//  All state/pos/vel updates happen only in the phy_tick cycle; outputs change 1 cycle after it.
//  IDLE, left and right requests both pending: left wins.
//   left req: x = max(x-WALK_STEP, X_MIN), face = 0.
//   right req: x = min(x+WALK_STEP, X_MAX), face = 1.
//   jump req (no walk req): cnt = 0, go to CHARGE.
//  CHARGE: if synced jump_btn = 1 and cnt < CHARGE_LEVELS*CHARGE_TICKS, cnt++.
//   Otherwise launch:
//    level = min(cnt/CHARGE_TICKS, CHARGE_LEVELS-1)+1;
//    vy = JUMP_VY*level; vx = JUMP_VX*level*(face ? 1 : -1), both clamped to +/-MAX_VEL;
//    pos unchanged; go to AIRBORNE.
//   Walk requests are ignored in CHARGE.
//  AIRBORNE, per tick:
//   xn = x+vx, yn = y+vy using old vel; vy = max(vy-GRAVITY, -MAX_VEL).
//   xn < X_MIN or xn > X_MAX: x clamped; vx = -vx; face toggles; wall_hit pulse.
//   yn > Y_MAX: y = Y_MAX; vy = 0.
//   yn <= Y_MIN: y = Y_MIN, vx = vy = 0, land pulse, go to LAND. Floor wins over a wall hit in the same tick (x still clamped).
//   All requests are ignored in AIRBORNE.
//  LAND: one-tick recovery, requests ignored; then IDLE.
//  Arithmetic: sums are computed at PHY_WIDTH+2 bits, then compared/clamped, so no wrap-around.
//  Reset mid-jump: every register returns to its reset value immediately.
// CONFIGURATION
//  CHAR_WALL_DAMP_EN defined: wall bounce sets vx = -(vx>>>1), rounded toward zero (4 -> -2).
//  CHAR_WALL_DAMP_EN undefined: magnitude is preserved (4 -> -4).
// TESTING
//  Reset -> pos (354,60), vel 0, face 1, state 0, on_ground 1, no pulses.
//  Right edge + tick -> x=356, face=1. Left+right edges before the same tick -> x=352, face=0.
//  Left at x=280 -> x stays 280.
//  Jump held 2 ticks, then released -> level 1, vy=8, vx=4.
//   17 airborne ticks; apex y=96; land pulse at y=60, x=422; LAND, then IDLE.
//  Same level-1 jump from x=420 -> 3rd airborne tick x=428, vx=-4 (-2 with CHAR_WALL_DAMP_EN), face=0, wall_hit.
//  Jump held 20 ticks -> auto-launch at cnt=16, level 4, vy=32.
//   9th airborne tick clamps y=308, vy=0.
//  Reset pulse mid-air; jump edge while AIRBORNE -> reset values restored; the jump edge has no effect.

Source files
------------

// File: rtl/char_physics_core.sv
// char_physics_core: character motion engine for the arena sprite.
// Buttons are synchronised and edge-detected into sticky walk/jump requests.
// Walking, charged jumps, gravity, and wall/ceiling/floor response advance
// only on the phy_tick strobe.
// Build option: define CHAR_WALL_DAMP_EN to halve |vx| on every side-wall
// bounce (rounded toward zero). Without it, a bounce only flips the sign of vx.
module char_physics_core #(
    parameter int PHY_WIDTH     = 10,
    parameter int MAP_X_OFFSET  = 270,
    parameter int MAP_Y_OFFSET  = 50,
    parameter int MAP_WIDTH_X   = 200,
    parameter int MAP_WIDTH_Y   = 300,
    parameter int WALL_WIDTH    = 10,
    parameter int CHAR_W        = 32,
    parameter int CHAR_H        = 32,
    parameter int GRAVITY       = 1,
    parameter int MAX_VEL       = 40,
    parameter int WALK_STEP     = 2,
    parameter int JUMP_VX       = 4,
    parameter int JUMP_VY       = 8,
    parameter int CHARGE_LEVELS = 4,
    parameter int CHARGE_TICKS  = 4
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        phy_tick,
    input  logic                        left_btn,
    input  logic                        right_btn,
    input  logic                        jump_btn,
    output logic signed [PHY_WIDTH:0]   pos_x,
    output logic signed [PHY_WIDTH:0]   pos_y,
    output logic signed [PHY_WIDTH:0]   vel_x,
    output logic signed [PHY_WIDTH:0]   vel_y,
    output logic                        face,
    output logic [1:0]                  state,
    output logic [2:0]                  charge_level,
    output logic                        on_ground,
    output logic                        wall_hit,
    output logic                        land
);

    // Stored width and the one-bit-wider working width for sums, so
    // position + velocity can never wrap before it is clamped.
    localparam int W  = PHY_WIDTH + 1;
    localparam int SW = PHY_WIDTH + 2;

    localparam int X_MIN_I  = MAP_X_OFFSET + WALL_WIDTH;
    localparam int X_MAX_I  = MAP_X_OFFSET + MAP_WIDTH_X - WALL_WIDTH - CHAR_W;
    localparam int Y_MIN_I  = MAP_Y_OFFSET + WALL_WIDTH;
    localparam int Y_MAX_I  = MAP_Y_OFFSET + MAP_WIDTH_Y - WALL_WIDTH - CHAR_H;
    localparam int INIT_X_I = X_MIN_I + (X_MAX_I - X_MIN_I) / 2;

    localparam logic signed [SW-1:0] X_MIN    = SW'(X_MIN_I);
    localparam logic signed [SW-1:0] X_MAX    = SW'(X_MAX_I);
    localparam logic signed [SW-1:0] Y_MIN    = SW'(Y_MIN_I);
    localparam logic signed [SW-1:0] Y_MAX    = SW'(Y_MAX_I);
    localparam logic signed [SW-1:0] STEP     = SW'(WALK_STEP);
    localparam logic signed [SW-1:0] GRAV     = SW'(GRAVITY);
    localparam logic signed [SW-1:0] NEG_VMAX = SW'(-MAX_VEL);

    localparam int CNT_MAX_I = CHARGE_LEVELS * CHARGE_TICKS;
    localparam int CW        = $clog2(CNT_MAX_I + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CNT_MAX_I);

    // Button bit positions inside the synchroniser / request vectors.
    localparam int B_LEFT  = 0;
    localparam int B_RIGHT = 1;
    localparam int B_JUMP  = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CHARGE   = 2'd1,
        ST_AIRBORNE = 2'd2,
        ST_LAND     = 2'd3
    } state_t;

    state_t         st;
    logic [CW-1:0]  charge_cnt;

    logic [2:0] btn_raw, btn_meta, btn_sync, btn_prev, btn_rise;
    logic [2:0] req_q, req;

    assign btn_raw = {jump_btn, right_btn, left_btn};
    assign state   = st;

    // Two-flop synchroniser plus a delayed copy for rising-edge detection.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            btn_meta <= '0;
            btn_sync <= '0;
            btn_prev <= '0;
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
        end
    end

    assign btn_rise = btn_sync & ~btn_prev;
    // An edge arriving in the tick cycle itself is consumed by that tick.
    assign req      = req_q | btn_rise;

    // Sticky request flags: collect edges between ticks, drop them on every tick.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            req_q <= '0;
        end else if (phy_tick) begin
            req_q <= '0;
        end else begin
            req_q <= req;
        end
    end

    logic signed [SW-1:0] x_ext, y_ext, vx_ext, vy_ext;
    logic signed [SW-1:0] x_walk_l, x_walk_r;
    logic signed [SW-1:0] xn, yn, x_clamped, vy_grav, vx_bounce;
    logic signed [SW-1:0] launch_vx, launch_vy;
    logic [2:0]           launch_level;
    logic                 hit_wall, hit_ceiling, hit_floor;
    int                   lvl_idx, mag_x, mag_y;
`ifdef CHAR_WALL_DAMP_EN
    logic signed [SW-1:0] vx_half;
`endif

    // Next-position candidates for walking, flight, and launch.
    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        x_ext  = {pos_x[W-1], pos_x};
        y_ext  = {pos_y[W-1], pos_y};
        vx_ext = {vel_x[W-1], vel_x};
        vy_ext = {vel_y[W-1], vel_y};

        x_walk_l = x_ext - STEP;
        if (x_walk_l < X_MIN) x_walk_l = X_MIN;
        x_walk_r = x_ext + STEP;
        if (x_walk_r > X_MAX) x_walk_r = X_MAX;

        // Flight step uses the velocity from before this tick.
        xn = x_ext + vx_ext;
        yn = y_ext + vy_ext;
        vy_grav = vy_ext - GRAV;
        if (vy_grav < NEG_VMAX) vy_grav = NEG_VMAX;

        hit_wall    = (xn < X_MIN) || (xn > X_MAX);
        hit_ceiling = (yn > Y_MAX);
        hit_floor   = (yn <= Y_MIN);
        x_clamped   = (xn < X_MIN) ? X_MIN : ((xn > X_MAX) ? X_MAX : xn);

`ifdef CHAR_WALL_DAMP_EN
        // Halve magnitude toward zero, then reverse direction.
        vx_half   = vx_ext[SW-1] ? -((-vx_ext) >>> 1) : (vx_ext >>> 1);
        vx_bounce = -vx_half;
`else
        vx_bounce = -vx_ext;
`endif

        // Charge level is 1-based and saturates at CHARGE_LEVELS.
        lvl_idx = int'(charge_cnt) / CHARGE_TICKS;
        if (lvl_idx > CHARGE_LEVELS - 1) lvl_idx = CHARGE_LEVELS - 1;
        launch_level = 3'(lvl_idx + 1);
        mag_x = JUMP_VX * (lvl_idx + 1);
        if (mag_x > MAX_VEL) mag_x = MAX_VEL;
        mag_y = JUMP_VY * (lvl_idx + 1);
        if (mag_y > MAX_VEL) mag_y = MAX_VEL;
        launch_vx = face ? SW'(mag_x) : SW'(-mag_x);
        launch_vy = SW'(mag_y);
    end

    // Motion FSM: all state, position, velocity and pulses update on phy_tick.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            st           <= ST_IDLE;
            pos_x        <= W'(INIT_X_I);
            pos_y        <= W'(Y_MIN_I);
            vel_x        <= '0;
            vel_y        <= '0;
            face         <= 1'b1;
            charge_cnt   <= '0;
            charge_level <= '0;
            on_ground    <= 1'b1;
            wall_hit     <= 1'b0;
            land         <= 1'b0;
        end else begin
            wall_hit <= 1'b0;
            land     <= 1'b0;
            if (phy_tick) begin
                unique case (st)
                    ST_IDLE: begin
                        if (req[B_LEFT]) begin
                            pos_x <= W'(x_walk_l);
                            face  <= 1'b0;
                        end else if (req[B_RIGHT]) begin
                            pos_x <= W'(x_walk_r);
                            face  <= 1'b1;
                        end else if (req[B_JUMP]) begin
                            charge_cnt <= '0;
                            st         <= ST_CHARGE;
                        end
                    end
                    ST_CHARGE: begin
                        if (btn_sync[B_JUMP] && (charge_cnt < CNT_MAX)) begin
                            charge_cnt <= charge_cnt + CW'(1);
                        end else begin
                            vel_x        <= W'(launch_vx);
                            vel_y        <= W'(launch_vy);
                            charge_level <= launch_level;
                            on_ground    <= 1'b0;
                            st           <= ST_AIRBORNE;
                        end
                    end
                    ST_AIRBORNE: begin
                        pos_x <= W'(x_clamped);
                        if (hit_floor) begin
                            // Floor contact takes precedence over a side wall.
                            pos_y     <= W'(Y_MIN);
                            vel_x     <= '0;
                            vel_y     <= '0;
                            land      <= 1'b1;
                            on_ground <= 1'b1;
                            st        <= ST_LAND;
                        end else begin
                            if (hit_ceiling) begin
                                pos_y <= W'(Y_MAX);
                                vel_y <= '0;
                            end else begin
                                pos_y <= W'(yn);
                                vel_y <= W'(vy_grav);
                            end
                            if (hit_wall) begin
                                vel_x    <= W'(vx_bounce);
                                face     <= ~face;
                                wall_hit <= 1'b1;
                            end
                        end
                    end
                    ST_LAND: begin
                        st <= ST_IDLE;
                    end
                    default: begin
                        st <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_char_physics_core.sv
// tb_char_physics_core: directed scenarios for char_physics_core.
// Stimulus pushes the expected outputs for each tick (or explicit sample)
// into a queue. A monitor pops one entry in the cycle after each tick and
// compares every field that entry cares about.
module tb_char_physics_core;

    localparam int D = -9999;   // don't-care marker for an expectation field

`ifdef CHAR_WALL_DAMP_EN
    localparam int L1_BOUNCE_VX = -2;
    localparam int L1_AFTER_X   = 426;
    localparam int L4_BOUNCE_VX = -8;
`else
    localparam int L1_BOUNCE_VX = -4;
    localparam int L1_AFTER_X   = 424;
    localparam int L4_BOUNCE_VX = -16;
`endif

    logic               sys_clk;
    logic               sys_rst_n;
    logic               phy_tick;
    logic               left_btn, right_btn, jump_btn;
    logic signed [10:0] pos_x, pos_y, vel_x, vel_y;
    logic               face;
    logic [1:0]         state;
    logic [2:0]         charge_level;
    logic               on_ground, wall_hit, land;
    logic               sample_req;

    int n_checks = 0;
    int n_errors = 0;
    int tag_cnt  = 0;

    typedef struct {
        int tag;
        int px, py, vx, vy, face, st, lvl, gnd, wh, ld;
    } exp_t;

    exp_t sb_q[$];

    char_physics_core dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .phy_tick     (phy_tick),
        .left_btn     (left_btn),
        .right_btn    (right_btn),
        .jump_btn     (jump_btn),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .vel_x        (vel_x),
        .vel_y        (vel_y),
        .face         (face),
        .state        (state),
        .charge_level (charge_level),
        .on_ground    (on_ground),
        .wall_hit     (wall_hit),
        .land         (land)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic exp_t mk(int px, int py, int vx, int vy, int fc,
                                int st, int lvl, int gnd, int wh, int ld);
        exp_t e;
        e.tag = 0;
        e.px = px; e.py = py; e.vx = vx; e.vy = vy; e.face = fc;
        e.st = st; e.lvl = lvl; e.gnd = gnd; e.wh = wh; e.ld = ld;
        return e;
    endfunction

    task automatic check(input int tag, input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL #%0d %s: actual %0d, expected %0d", tag, name, act, exp);
        end
    endtask

    task automatic cmp(input int tag, input string name, input int act, input int exp);
        if (exp != D) check(tag, name, act, exp);
    endtask

    // Issue one tick (or a plain sample) and queue what should be seen after it.
    task automatic issue(input bit is_tick, input exp_t e);
        @(posedge sys_clk);
        #1;
        tag_cnt++;
        e.tag = tag_cnt;
        sb_q.push_back(e);
        phy_tick   = is_tick;
        sample_req = !is_tick;
        @(posedge sys_clk);
        #1;
        phy_tick   = 1'b0;
        sample_req = 1'b0;
    endtask

    task automatic tick(input exp_t e);
        issue(1'b1, e);
    endtask

    task automatic sample_now(input exp_t e);
        issue(1'b0, e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Press and release the selected buttons so that one edge is latched.
    task automatic pulse_btn(input bit l, input bit r, input bit j);
        left_btn = l; right_btn = r; jump_btn = j;
        wait_cycles(4);
        left_btn = 1'b0; right_btn = 1'b0; jump_btn = 1'b0;
        wait_cycles(4);
    endtask

    task automatic do_reset();
        @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b0;
        left_btn = 1'b0; right_btn = 1'b0; jump_btn = 1'b0;
        wait_cycles(3);
        sys_rst_n = 1'b1;
        wait_cycles(4);
    endtask

    // Monitor: one scoreboard entry per tick or sample request.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge sys_clk);
            if (phy_tick || sample_req) begin
                @(negedge sys_clk);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL scoreboard_underflow: output event with no expectation queued");
                end else begin
                    e = sb_q.pop_front();
                    cmp(e.tag, "pos_x",        int'(pos_x),        e.px);
                    cmp(e.tag, "pos_y",        int'(pos_y),        e.py);
                    cmp(e.tag, "vel_x",        int'(vel_x),        e.vx);
                    cmp(e.tag, "vel_y",        int'(vel_y),        e.vy);
                    cmp(e.tag, "face",         int'(face),         e.face);
                    cmp(e.tag, "state",        int'(state),        e.st);
                    cmp(e.tag, "charge_level", int'(charge_level), e.lvl);
                    cmp(e.tag, "on_ground",    int'(on_ground),    e.gnd);
                    cmp(e.tag, "wall_hit",     int'(wall_hit),     e.wh);
                    cmp(e.tag, "land",         int'(land),         e.ld);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    // Flight heights for the level-1 jump from the floor, one per airborne tick.
    int l1_y [17] = '{68, 75, 81, 86, 90, 93, 95, 96, 96, 95, 93, 90, 86, 81, 75, 68, 60};

    initial begin : stimulus
        sys_rst_n  = 1'b0;
        phy_tick   = 1'b0;
        sample_req = 1'b0;
        left_btn   = 1'b0;
        right_btn  = 1'b0;
        jump_btn   = 1'b0;
        wait_cycles(3);
        sys_rst_n = 1'b1;
        wait_cycles(4);

        // Reset state.
        sample_now(mk(354, 60, 0, 0, 1, 0, 0, 1, 0, 0));

        // Single right step.
        pulse_btn(1'b0, 1'b1, 1'b0);
        tick(mk(356, 60, 0, 0, 1, 0, 0, 1, 0, 0));

        // Left and right in the same tick window: left wins.
        do_reset();
        pulse_btn(1'b1, 1'b1, 1'b0);
        tick(mk(352, 60, D, D, 0, 0, D, 1, D, D));

        // Walk left to the wall and then push against it.
        for (int i = 1; i <= 36; i++) begin
            pulse_btn(1'b1, 1'b0, 1'b0);
            tick(mk(352 - 2 * i, D, D, D, 0, 0, D, D, D, D));
        end
        pulse_btn(1'b1, 1'b0, 1'b0);
        tick(mk(280, 60, 0, 0, 0, 0, D, 1, 0, 0));

        // Level-1 jump: two charge ticks, release, fly 17 ticks, land, recover.
        do_reset();
        jump_btn = 1'b1;
        wait_cycles(4);
        tick(mk(354, 60, 0, 0, 1, 1, 0, 1, D, D));
        tick(mk(354, 60, 0, 0, 1, 1, 0, 1, D, D));
        jump_btn = 1'b0;
        wait_cycles(4);
        tick(mk(354, 60, 4, 8, 1, 2, 1, 0, 0, 0));
        for (int k = 1; k <= 16; k++) begin
            tick(mk(354 + 4 * k, l1_y[k-1], 4, 8 - k, 1, 2, D, 0, 0, 0));
        end
        tick(mk(422, l1_y[16], 0, 0, 1, 3, 1, 1, 0, 1));
        tick(mk(422, 60, 0, 0, 1, 0, 1, 1, 0, 0));

        // Level-1 jump from x=420 bounces off the right wall on the 3rd airborne tick.
        do_reset();
        for (int i = 1; i <= 33; i++) begin
            pulse_btn(1'b0, 1'b1, 1'b0);
            tick(mk(354 + 2 * i, D, D, D, 1, 0, D, D, D, D));
        end
        jump_btn = 1'b1;
        wait_cycles(4);
        tick(mk(420, 60, D, D, D, 1, D, 1, D, D));
        tick(mk(420, 60, D, D, D, 1, D, 1, D, D));
        jump_btn = 1'b0;
        wait_cycles(4);
        tick(mk(420, 60, 4, 8, 1, 2, 1, 0, D, D));
        tick(mk(424, 68, 4, 7, 1, 2, D, D, 0, D));
        tick(mk(428, 75, 4, 6, 1, 2, D, D, 0, D));
        tick(mk(428, 81, L1_BOUNCE_VX, 5, 0, 2, D, D, 1, 0));
        tick(mk(L1_AFTER_X, 86, L1_BOUNCE_VX, 4, 0, 2, D, D, 0, D));

        // A jump edge while airborne is ignored.
        jump_btn = 1'b1;
        wait_cycles(4);
        tick(mk(D, 90, D, 3, 0, 2, 1, 0, D, D));
        jump_btn = 1'b0;
        wait_cycles(4);
        jump_btn = 1'b1;
        wait_cycles(4);

        // Asynchronous reset mid-air with a jump edge still latched.
        #3;
        sys_rst_n = 1'b0;
        jump_btn  = 1'b0;
        sample_now(mk(354, 60, 0, 0, 1, 0, 0, 1, 0, 0));
        sys_rst_n = 1'b1;
        wait_cycles(4);
        tick(mk(354, 60, 0, 0, 1, 0, 0, 1, 0, 0));

        // Jump held for 20 ticks: auto-launch at full charge, wall hit, ceiling clamp.
        jump_btn = 1'b1;
        wait_cycles(4);
        for (int t = 1; t <= 17; t++) begin
            tick(mk(354, 60, 0, 0, 1, 1, 0, 1, D, D));
        end
        tick(mk(354, 60, 16, 32, 1, 2, 4, 0, 0, 0));
        tick(mk(370, 92, 16, 31, 1, 2, 4, 0, 0, 0));
        tick(mk(386, 123, 16, 30, 1, 2, 4, 0, 0, 0));
        jump_btn = 1'b0;
        tick(mk(402, 153, 16, 29, 1, 2, D, D, 0, D));
        tick(mk(418, 182, 16, 28, 1, 2, D, D, 0, D));
        tick(mk(428, 210, L4_BOUNCE_VX, 27, 0, 2, D, D, 1, 0));
        tick(mk(D, 237, L4_BOUNCE_VX, 26, 0, 2, D, D, 0, D));
        tick(mk(D, 263, D, 25, D, 2, D, D, D, D));
        tick(mk(D, 288, D, 24, D, 2, D, D, D, D));
        tick(mk(D, 308, D, 0, D, 2, 4, 0, D, 0));
        tick(mk(D, 308, D, -1, D, 2, D, D, D, D));

        wait_cycles(5);
        check(0, "scoreboard_drain", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
